// File: rtl/uart_transmitter_if.sv
// uart_transmitter_if: baud tick, start/data request and serial line status of a UART transmitter.
interface uart_transmitter_if #(
  parameter int DATA_BITS = 32
);
  logic                 i_bd_tick;
  logic                 i_tx_start;
  logic [DATA_BITS-1:0] i_data;
  logic                 o_tx;
  logic                 o_tx_done;
  logic                 o_busy;
  modport master (output i_bd_tick, i_tx_start, i_data, input o_tx, o_tx_done, o_busy);
  modport slave (input i_bd_tick, i_tx_start, i_data, output o_tx, o_tx_done, o_busy);
endinterface

// File: rtl/uart_transmitter.sv
// uart_transmitter: one start bit, DATA_BITS data bits LSB first, one stop bit; STP_BITS_TICKS baud ticks per bit.
module uart_transmitter #(
  parameter int DATA_BITS      = 32,
  parameter int STP_BITS_TICKS = 16
) (
  input logic               i_clk,
  input logic               i_reset_n,
  uart_transmitter_if.slave bus
);
  localparam int TW = STP_BITS_TICKS > 1 ? $clog2(STP_BITS_TICKS) : 1;
  localparam int BW = $clog2(DATA_BITS);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t               state;
  logic [TW-1:0]        tick_cnt;
  logic [BW-1:0]        bit_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 bit_end;
  assign bit_end = bus.i_bd_tick && tick_cnt == TW'(STP_BITS_TICKS - 1);
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state         <= IDLE;
      tick_cnt      <= '0;
      bit_cnt       <= '0;
      shreg         <= '0;
      bus.o_tx      <= 1'b1;
      bus.o_tx_done <= 1'b0;
      bus.o_busy    <= 1'b0;
    end else begin
      bus.o_tx_done <= 1'b0;
      // Ticks only count once a frame is underway; the accept-cycle tick is dropped.
      if (state != IDLE && bus.i_bd_tick) tick_cnt <= bit_end ? '0 : tick_cnt + 1'b1;
      case (state)
        IDLE: if (bus.i_tx_start) begin
          shreg      <= bus.i_data;
          state      <= START;
          bus.o_tx   <= 1'b0;
          bus.o_busy <= 1'b1;
        end
        START: if (bit_end) begin
          bit_cnt  <= '0;
          state    <= DATA;
          bus.o_tx <= shreg[0];
        end
        DATA: if (bit_end) begin
          shreg <= shreg >> 1;
          if (bit_cnt == BW'(DATA_BITS - 1)) begin
            state    <= STOP;
            bus.o_tx <= 1'b1;
          end else begin
            bit_cnt  <= bit_cnt + 1'b1;
            bus.o_tx <= shreg[1];
          end
        end
        default: if (bit_end) begin
          state         <= IDLE;
          bus.o_tx_done <= 1'b1;
          bus.o_busy    <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_uart_transmitter.sv
// tb_uart_transmitter: drives 8-bit and 32-bit transmitters and checks the line, per baud tick, against a frame model.
module tb_uart_transmitter;
  localparam int S = 16;
  logic clk = 1'b0, rst_n = 1'b1, tick = 1'b0;
  int   n_chk = 0, n_pass = 0;
  logic q[$];
  int   dpos[$];
  int   busy_drop, busy_at_done, cyc;

  uart_transmitter_if #(.DATA_BITS(8))  b8 ();
  uart_transmitter_if #(.DATA_BITS(32)) b32 ();
  assign b8.i_bd_tick  = tick;
  assign b32.i_bd_tick = tick;

  uart_transmitter #(.DATA_BITS(8), .STP_BITS_TICKS(S)) dut8 (.i_clk(clk), .i_reset_n(rst_n), .bus(b8));
  uart_transmitter dut32 (.i_clk(clk), .i_reset_n(rst_n), .bus(b32));

  always #5 clk = ~clk;

  // Line level seen at the k-th counted tick of a frame: start, data LSB first, then stop.
  function automatic logic line_bit(int n, logic [31:0] d, int k);
    int b = k / S;
    return b == 0 ? 1'b0 : b > n ? 1'b1 : d[b-1];
  endfunction

  function automatic int frame_err(int n, logic [31:0] d, int base);
    int e = 0;
    for (int k = 0; k < (n + 2) * S; k++)
      if (base + k >= q.size() || q[base+k] !== line_bit(n, d, k)) e++;
    return e;
  endfunction

  // Receiver-style decode: sample each data bit at its centre tick.
  function automatic logic [31:0] decode(int n, int base);
    logic [31:0] w = '0;
    for (int i = 0; i < n; i++) begin
      int idx = base + S * (i + 1) + S / 2;
      w[i] = idx < q.size() ? q[idx] : 1'bx;
    end
    return w;
  endfunction

  task automatic clr();
    q.delete();
    dpos.delete();
    busy_drop = 0;
    busy_at_done = 0;
    cyc = 0;
  endtask

  task automatic run(input bit w, input int period, input int n);
    repeat (n) begin
      tick = (cyc % period) == 0;
      cyc++;
      if ((w ? b32.o_tx_done : b8.o_tx_done) === 1'b1) begin
        dpos.push_back(q.size());
        if ((w ? b32.o_busy : b8.o_busy) !== 1'b0) busy_at_done++;
      end else if (dpos.size() == 0 && (w ? b32.o_busy : b8.o_busy) !== 1'b1) busy_drop++;
      if (tick) q.push_back(w ? b32.o_tx : b8.o_tx);
      @(negedge clk);
    end
  endtask

  task automatic accept(input bit w, input logic [31:0] d);
    if (w) begin b32.i_tx_start = 1'b1; b32.i_data = d; end
    else begin b8.i_tx_start = 1'b1; b8.i_data = d[7:0]; end
    tick = 1'b1;
    @(negedge clk);
    b8.i_tx_start = 1'b0;
    b32.i_tx_start = 1'b0;
    clr();
  endtask

  task automatic test_reset();
    #3 rst_n = 1'b0;
    #1;
    n_chk++; if (b8.o_tx !== 1'b1) $display("FAIL reset_tx8: got %b want 1", b8.o_tx); else n_pass++;
    n_chk++; if (b8.o_busy !== 1'b0) $display("FAIL reset_busy8: got %b want 0", b8.o_busy); else n_pass++;
    n_chk++; if (b8.o_tx_done !== 1'b0) $display("FAIL reset_done8: got %b want 0", b8.o_tx_done); else n_pass++;
    n_chk++; if ({b32.o_tx, b32.o_busy, b32.o_tx_done} !== 3'b100) $display("FAIL reset_32: got %b want 100", {b32.o_tx, b32.o_busy, b32.o_tx_done}); else n_pass++;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      n_chk++; if ({b8.o_tx, b8.o_busy, b8.o_tx_done} !== 3'b100) $display("FAIL reset_hold: got %b want 100", {b8.o_tx, b8.o_busy, b8.o_tx_done}); else n_pass++;
    end
  endtask

  task automatic test_a5();
    accept(1'b0, 32'hA5);
    b8.i_data = 8'h00;
    run(1'b0, 1, 10 * S + 5);
    n_chk++; if (frame_err(8, 32'hA5, 0) !== 0) $display("FAIL a5_line: got %0d bad ticks want 0", frame_err(8, 32'hA5, 0)); else n_pass++;
    n_chk++; if (dpos.size() !== 1) $display("FAIL a5_done_count: got %0d want 1", dpos.size()); else n_pass++;
    n_chk++; if ((dpos.size() ? dpos[0] : -1) !== 10 * S) $display("FAIL a5_frame_len: got %0d want %0d", dpos.size() ? dpos[0] : -1, 10 * S); else n_pass++;
    n_chk++; if (busy_drop + busy_at_done !== 0) $display("FAIL a5_busy: got %0d bad cycles want 0", busy_drop + busy_at_done); else n_pass++;
    n_chk++; if (decode(8, 0) !== 32'hA5) $display("FAIL a5_decode: got %h want a5", decode(8, 0)); else n_pass++;
  endtask

  task automatic test_loop32();
    accept(1'b1, 32'h12345678);
    b32.i_data = $urandom;
    run(1'b1, 4, 34 * S * 4 + 8);
    n_chk++; if (decode(32, 0) !== 32'h12345678) $display("FAIL w32_decode: got %h want 12345678", decode(32, 0)); else n_pass++;
    n_chk++; if (frame_err(32, 32'h12345678, 0) !== 0) $display("FAIL w32_line: got %0d bad ticks want 0", frame_err(32, 32'h12345678, 0)); else n_pass++;
    n_chk++; if ((dpos.size() == 1 ? dpos[0] : -1) !== 34 * S) $display("FAIL w32_frame_len: got %0d want %0d", dpos.size() == 1 ? dpos[0] : -1, 34 * S); else n_pass++;
    n_chk++; if (busy_drop + busy_at_done !== 0) $display("FAIL w32_busy: got %0d bad cycles want 0", busy_drop + busy_at_done); else n_pass++;
  endtask

  task automatic test_random();
    for (int i = 0; i < 5; i++) begin
      bit          w = i == 4;
      int          n = w ? 32 : 8;
      int          p = w ? 2 : $urandom_range(1, 3);
      logic [31:0] d = w ? $urandom : 32'($urandom_range(0, 255));
      accept(w, d);
      run(w, p, (n + 2) * S * p + 8);
      n_chk++; if (frame_err(n, d, 0) !== 0) $display("FAIL rand_line[%0d]: got %0d bad ticks want 0 (data %h period %0d)", i, frame_err(n, d, 0), d, p); else n_pass++;
      n_chk++; if ((dpos.size() == 1 ? dpos[0] : -1) !== (n + 2) * S) $display("FAIL rand_frame_len[%0d]: got %0d want %0d", i, dpos.size() == 1 ? dpos[0] : -1, (n + 2) * S); else n_pass++;
    end
  endtask

  task automatic test_start_busy();
    accept(1'b0, 32'h3C);
    run(1'b0, 1, 40);
    b8.i_tx_start = 1'b1;
    b8.i_data = 8'hFF;
    run(1'b0, 1, 1);
    b8.i_tx_start = 1'b0;
    run(1'b0, 1, 300);
    n_chk++; if (frame_err(8, 32'h3C, 0) !== 0) $display("FAIL busy_line: got %0d bad ticks want 0", frame_err(8, 32'h3C, 0)); else n_pass++;
    n_chk++; if (decode(8, 0) !== 32'h3C) $display("FAIL busy_decode: got %h want 3c", decode(8, 0)); else n_pass++;
    n_chk++; if (dpos.size() !== 1) $display("FAIL busy_done_count: got %0d want 1", dpos.size()); else n_pass++;
    n_chk++; if (b8.o_busy !== 1'b0) $display("FAIL busy_idle_after: got %b want 0", b8.o_busy); else n_pass++;
  endtask

  task automatic test_back_to_back();
    b8.i_tx_start = 1'b1;
    b8.i_data = 8'h01;
    tick = 1'b1;
    @(negedge clk);
    b8.i_data = 8'h80;
    clr();
    run(1'b0, 1, 200);
    b8.i_tx_start = 1'b0;
    run(1'b0, 1, 200);
    n_chk++; if (dpos.size() !== 2) $display("FAIL b2b_done_count: got %0d want 2", dpos.size()); else n_pass++;
    n_chk++; if ((dpos.size() == 2 ? dpos[1] : -1) !== 20 * S + 1) $display("FAIL b2b_second_done: got %0d want %0d", dpos.size() == 2 ? dpos[1] : -1, 20 * S + 1); else n_pass++;
    n_chk++; if (frame_err(8, 32'h01, 0) + frame_err(8, 32'h80, 10 * S + 1) !== 0) $display("FAIL b2b_line: got %0d bad ticks want 0", frame_err(8, 32'h01, 0) + frame_err(8, 32'h80, 10 * S + 1)); else n_pass++;
    n_chk++; if ((q.size() > 10 * S ? q[10*S] : 1'bx) !== 1'b1) $display("FAIL b2b_gap: got %b want 1", q.size() > 10 * S ? q[10*S] : 1'bx); else n_pass++;
    n_chk++; if ({decode(8, 0), decode(8, 10 * S + 1)} !== {32'h01, 32'h80}) $display("FAIL b2b_decode: got %h %h want 01 80", decode(8, 0), decode(8, 10 * S + 1)); else n_pass++;
  endtask

  task automatic test_reset_mid();
    int zeros = 0;
    accept(1'b0, 32'h96);
    run(1'b0, 1, 4 * S + 5);
    n_chk++; if (b8.o_tx !== line_bit(8, 32'h96, 4 * S + 5)) $display("FAIL mid_before: got %b want %b", b8.o_tx, line_bit(8, 32'h96, 4 * S + 5)); else n_pass++;
    #2 rst_n = 1'b0;
    #1;
    n_chk++; if ({b8.o_tx, b8.o_busy, b8.o_tx_done} !== 3'b100) $display("FAIL mid_reset: got %b want 100", {b8.o_tx, b8.o_busy, b8.o_tx_done}); else n_pass++;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    clr();
    run(1'b0, 1, 200);
    foreach (q[i]) if (q[i] !== 1'b1) zeros++;
    n_chk++; if (dpos.size() + zeros !== 0) $display("FAIL mid_abandon: got %0d done pulses %0d low ticks want 0 0", dpos.size(), zeros); else n_pass++;
    accept(1'b0, 32'h5A);
    run(1'b0, 1, 10 * S + 5);
    n_chk++; if (frame_err(8, 32'h5A, 0) !== 0) $display("FAIL mid_resend_line: got %0d bad ticks want 0", frame_err(8, 32'h5A, 0)); else n_pass++;
    n_chk++; if ((dpos.size() == 1 ? dpos[0] : -1) !== 10 * S) $display("FAIL mid_resend_len: got %0d want %0d", dpos.size() == 1 ? dpos[0] : -1, 10 * S); else n_pass++;
  endtask

  initial begin
    b8.i_tx_start = 1'b0;
    b8.i_data = '0;
    b32.i_tx_start = 1'b0;
    b32.i_data = '0;
    test_reset();
    test_a5();
    test_loop32();
    test_random();
    test_start_busy();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
